// File: rtl/mc_datapath_p_if.sv
// Memory-side bus of the multicycle datapath: address and store data go out,
// read data and the ready handshake come back in.
interface mc_datapath_p_if #(parameter int WIDTH = 16);
   logic             mem_ready;
   logic [WIDTH-1:0] readdata;
   logic [WIDTH-1:0] adr;
   logic [WIDTH-1:0] writedata;

   modport master (input mem_ready, input readdata, output adr, output writedata);
   modport slave  (output mem_ready, output readdata, input adr, input writedata);
endinterface

// File: rtl/mc_datapath_p.sv
// Multicycle processor datapath: PC, IR, 8-entry register file, ALU with carry/zero
// flags and cz-conditional writeback, all frozen while memory is not ready.
module mc_datapath_p #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   mc_datapath_p_if.master      bus,
   input  logic                 pcen,
   input  logic                 irwrite,
   input  logic                 regwrite,
   input  logic                 condwb,
   input  logic                 flagwrite,
   input  logic                 alusrca,
   input  logic                 iord,
   input  logic                 memtoreg,
   input  logic [1:0]           regdst,
   input  logic [1:0]           alusrcb,
   input  logic [1:0]           pcsrc,
   input  logic [2:0]           alucontrol,
   output logic [3:0]           op,
   output logic [1:0]           cz,
   output logic                 zero,
   output logic                 carry_flag,
   output logic                 zero_flag,
   output logic                 wb_suppressed
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [15:0]      instr_q, instr_d;
   logic [WIDTH-1:0] a_q, b_q, dataReg_q, aluOut_q;
   logic             carryFlag_q, carryFlag_d, zeroFlag_q, zeroFlag_d;
   logic [WIDTH-1:0] rf_q [8];

   logic [2:0]       ra, rb, rc, writeReg;
   logic [5:0]       imm6;
   logic [8:0]       imm9;
   logic [WIDTH-1:0] rd1, rd2, srcA, srcB, aluResult, pcNext, writeData;
   logic             aluCarry, czOk, condOk, rfWe;

   assign ra   = instr_q[11:9];
   assign rb   = instr_q[8:6];
   assign rc   = instr_q[5:3];
   assign imm6 = instr_q[5:0];
   assign imm9 = instr_q[8:0];

   assign op            = instr_q[15:12];
   assign cz            = instr_q[1:0];
   assign carry_flag    = carryFlag_q;
   assign zero_flag     = zeroFlag_q;
   assign bus.adr       = iord ? aluOut_q : pc_q;
   assign bus.writedata = b_q;

   assign rd1  = rf_q[ra];
   assign rd2  = rf_q[rb];
   assign srcA = alusrca ? a_q : pc_q;

   always_comb begin
      srcB = b_q;
      unique case (alusrcb)
         2'b00: srcB = b_q;
         2'b01: srcB = {{(WIDTH-1){1'b0}}, 1'b1};
         2'b10: srcB = {{(WIDTH-6){imm6[5]}}, imm6};
         2'b11: srcB = {{(WIDTH-9){imm9[8]}}, imm9};
         default: srcB = b_q;
      endcase
   end

   // Carry is meaningful only for add (carry out) and sub (unsigned borrow).
   always_comb begin
      aluResult = '0;
      aluCarry  = 1'b0;
      unique case (alucontrol)
         3'b000: {aluCarry, aluResult} = {1'b0, srcA} + {1'b0, srcB};
         3'b001: begin
            aluResult = srcA - srcB;
            aluCarry  = (srcA < srcB);
         end
         3'b010: aluResult = srcA & srcB;
         3'b011: aluResult = srcA | srcB;
         3'b100: aluResult = ~(srcA & srcB);
         3'b101: aluResult = srcA ^ srcB;
         3'b110: aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         3'b111: aluResult = srcB;
         default: aluResult = '0;
      endcase
   end

   assign zero = (aluResult == '0);

   // The condition looks at the flags as they stand now, not the ones being written.
   always_comb begin
      czOk = 1'b1;
      unique case (cz)
         2'b10:   czOk = carryFlag_q;
         2'b01:   czOk = zeroFlag_q;
         default: czOk = 1'b1;
      endcase
   end

   assign condOk        = ~condwb | czOk;
   assign wb_suppressed = regwrite & condwb & ~czOk;
   assign rfWe          = regwrite & condOk & bus.mem_ready;
   assign writeData     = memtoreg ? dataReg_q : aluOut_q;

   always_comb begin
      writeReg = rc;
      unique case (regdst)
         2'b01:   writeReg = rb;
         2'b10:   writeReg = ra;
         default: writeReg = rc;
      endcase
   end

   always_comb begin
      pcNext = pc_q;
      unique case (pcsrc)
         2'b00:   pcNext = aluResult;
         2'b01:   pcNext = aluOut_q;
         2'b10:   pcNext = a_q;
         default: pcNext = pc_q;
      endcase
   end

   always_comb begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      carryFlag_d = carryFlag_q;
      zeroFlag_d  = zeroFlag_q;
      if (bus.mem_ready) begin
         if (pcen)
            pc_d = pcNext;
         if (irwrite)
            instr_d = bus.readdata[15:0];
         if (flagwrite) begin
            carryFlag_d = aluCarry;
            zeroFlag_d  = zero;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         dataReg_q   <= '0;
         aluOut_q    <= '0;
         carryFlag_q <= 1'b0;
         zeroFlag_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         carryFlag_q <= carryFlag_d;
         zeroFlag_q  <= zeroFlag_d;
         if (bus.mem_ready) begin
            a_q       <= rd1;
            b_q       <= rd2;
            dataReg_q <= bus.readdata;
            aluOut_q  <= aluResult;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++)
            rf_q[i] <= '0;
      end else if (rfWe) begin
         rf_q[writeReg] <= writeData;
      end
   end

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p: a spec-level model is checked every cycle,
// plus literal expectations at the key scenario points.
module tb_mc_datapath_p;
   localparam int WIDTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pcen = 1'b0, irwrite = 1'b0, regwrite = 1'b0, condwb = 1'b0, flagwrite = 1'b0;
   logic       alusrca = 1'b0, iord = 1'b0, memtoreg = 1'b0;
   logic [1:0] regdst = 2'b00, alusrcb = 2'b00, pcsrc = 2'b00;
   logic [2:0] alucontrol = 3'b000;
   logic [3:0] op;
   logic [1:0] cz;
   logic       zero, carry_flag, zero_flag, wb_suppressed;

   int total = 0;
   int bad = 0;

   mc_datapath_p_if #(.WIDTH(WIDTH)) bus ();

   mc_datapath_p #(.WIDTH(WIDTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .condwb(condwb),
      .flagwrite(flagwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
      .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
      .op(op), .cz(cz), .zero(zero), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .wb_suppressed(wb_suppressed)
   );

   always #5 clk = ~clk;

   // Architectural model state, held as plain integers masked to 16 bits.
   int mPc, mIr, mA, mB, mDr, mAlu, mCf, mZf;
   int mRf [8];
   bit modelValid = 1'b0;

   function automatic int sext(input int v, input int bits);
      if (v >= (1 << (bits - 1)))
         return (v - (1 << bits)) & 32'hFFFF;
      return v;
   endfunction

   function automatic int toSigned(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   function automatic int opA();
      return alusrca ? mA : mPc;
   endfunction

   function automatic int opB();
      case (alusrcb)
         2'd0:    return mB;
         2'd1:    return 1;
         2'd2:    return sext(mIr & 63, 6);
         default: return sext(mIr & 511, 9);
      endcase
   endfunction

   // Returns (carry << 16) | result for the current inputs and model state.
   function automatic int aluCalc();
      int x, y, r, c;
      x = opA();
      y = opB();
      c = 0;
      case (alucontrol)
         3'd0: begin r = x + y; c = r >> 16; r = r & 32'hFFFF; end
         3'd1: begin r = (x - y) & 32'hFFFF; c = (x < y) ? 1 : 0; end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = (~(x & y)) & 32'hFFFF;
         3'd5: r = x ^ y;
         3'd6: r = (toSigned(x) < toSigned(y)) ? 1 : 0;
         default: r = y;
      endcase
      return (c << 16) | r;
   endfunction

   function automatic bit condOk();
      int c;
      c = mIr & 3;
      if (!condwb) return 1'b1;
      if (c == 2) return mCf != 0;
      if (c == 1) return mZf != 0;
      return 1'b1;
   endfunction

   function automatic int dstReg();
      case (regdst)
         2'd1:    return (mIr >> 6) & 7;
         2'd2:    return (mIr >> 9) & 7;
         default: return (mIr >> 3) & 7;
      endcase
   endfunction

   function automatic int pcSel();
      case (pcsrc)
         2'd0:    return aluCalc() & 32'hFFFF;
         2'd1:    return mAlu;
         2'd2:    return mA;
         default: return mPc;
      endcase
   endfunction

   // Model advance on each rising edge, using the inputs that are stable at the edge.
   always @(posedge clk) begin
      if (reset) begin
         mPc <= 0; mIr <= 0; mA <= 0; mB <= 0; mDr <= 0; mAlu <= 0; mCf <= 0; mZf <= 0;
         for (int i = 0; i < 8; i++) mRf[i] <= 0;
         modelValid <= 1'b1;
      end else if (bus.mem_ready) begin
         if (regwrite && condOk()) mRf[dstReg()] <= memtoreg ? mDr : mAlu;
         if (pcen) mPc <= pcSel();
         if (irwrite) mIr <= int'(bus.readdata) & 32'hFFFF;
         mDr  <= int'(bus.readdata);
         mAlu <= aluCalc() & 32'hFFFF;
         mA   <= mRf[(mIr >> 9) & 7];
         mB   <= mRf[(mIr >> 6) & 7];
         if (flagwrite) begin
            mCf <= aluCalc() >> 16;
            mZf <= ((aluCalc() & 32'hFFFF) == 0) ? 1 : 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every falling edge: all DUT outputs and the register file against the model.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("op", int'(op), mIr >> 12);
         checkOutput("cz", int'(cz), mIr & 3);
         checkOutput("adr", int'(bus.adr), iord ? mAlu : mPc);
         checkOutput("writedata", int'(bus.writedata), mB);
         checkOutput("carry_flag", int'(carry_flag), mCf);
         checkOutput("zero_flag", int'(zero_flag), mZf);
         checkOutput("zero", int'(zero), ((aluCalc() & 32'hFFFF) == 0) ? 1 : 0);
         checkOutput("wb_suppressed", int'(wb_suppressed),
                     (regwrite && condwb && !condOk()) ? 1 : 0);
         for (int i = 0; i < 8; i++)
            checkOutput($sformatf("rf%0d", i), int'(dut.rf_q[i]), mRf[i]);
      end
   end

   task automatic applyStimulus(input int cycles = 1);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idleCtl();
      pcen = 0; irwrite = 0; regwrite = 0; condwb = 0; flagwrite = 0;
      alusrca = 0; iord = 0; memtoreg = 0;
      regdst = 2'b00; alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000;
      bus.mem_ready = 1'b1;
   endtask

   task automatic fetchCtl(input logic [15:0] word);
      idleCtl();
      irwrite = 1; pcen = 1; alusrcb = 2'b01; bus.readdata = word;
   endtask

   // Writes value into the register selected by regdst through the data register.
   task automatic loadReg(input logic [15:0] value, input logic [1:0] dst);
      idleCtl();
      bus.readdata = value;
      applyStimulus();
      memtoreg = 1; regwrite = 1; regdst = dst;
      applyStimulus();
      idleCtl();
      applyStimulus();
   endtask

   initial begin
      idleCtl();
      bus.readdata = '0;
      reset = 1;
      applyStimulus();
      reset = 0;
      checkOutput("rst_adr", int'(bus.adr), 0);
      checkOutput("rst_op", int'(op), 0);
      checkOutput("rst_cz", int'(cz), 0);
      checkOutput("rst_writedata", int'(bus.writedata), 0);
      checkOutput("rst_wbsup", int'(wb_suppressed), 0);
      checkOutput("rst_carry", int'(carry_flag), 0);

      fetchCtl(16'h1234);
      applyStimulus();
      checkOutput("fetch_pc", int'(bus.adr), 16'h0001);
      checkOutput("fetch_op", int'(op), 1);
      checkOutput("model_pc", mPc, 1);

      bus.mem_ready = 0;
      bus.readdata = 16'h5678;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("stall_pc", int'(bus.adr), 16'h0001);
         checkOutput("stall_op", int'(op), 1);
      end
      bus.mem_ready = 1;
      applyStimulus();
      checkOutput("unstall_pc", int'(bus.adr), 16'h0002);
      checkOutput("unstall_op", int'(op), 5);

      // ra=1, rb=2, rc=3, cz=10
      fetchCtl(16'h029A);
      applyStimulus();
      checkOutput("ir_cz", int'(cz), 2);

      loadReg(16'hFFFF, 2'b10);
      checkOutput("r1_load", int'(dut.rf_q[1]), 16'hFFFF);
      loadReg(16'h0001, 2'b01);
      checkOutput("b_is_r2", int'(bus.writedata), 16'h0001);

      alusrca = 1; alusrcb = 2'b00; alucontrol = 3'b000; flagwrite = 1;
      #1;
      checkOutput("add_zero_comb", int'(zero), 1);
      applyStimulus();
      checkOutput("add_carry", int'(carry_flag), 1);
      checkOutput("add_zflag", int'(zero_flag), 1);
      flagwrite = 0; iord = 1;
      #1;
      checkOutput("add_aluout", int'(bus.adr), 16'h0000);

      iord = 0; alucontrol = 3'b010; flagwrite = 1; bus.readdata = 16'h00CD;
      applyStimulus();
      checkOutput("and_carry", int'(carry_flag), 0);

      flagwrite = 0; condwb = 1; regwrite = 1; regdst = 2'b00; memtoreg = 1;
      #1;
      checkOutput("sup_flag", int'(wb_suppressed), 1);
      applyStimulus();
      checkOutput("sup_r3", int'(dut.rf_q[3]), 0);

      condwb = 0; regwrite = 0; memtoreg = 0;
      alucontrol = 3'b000; flagwrite = 1; bus.readdata = 16'h00AB;
      applyStimulus();
      checkOutput("set_carry", int'(carry_flag), 1);

      flagwrite = 0; condwb = 1; regwrite = 1; regdst = 2'b00; memtoreg = 1;
      #1;
      checkOutput("wr_flag", int'(wb_suppressed), 0);
      applyStimulus();
      checkOutput("wr_r3", int'(dut.rf_q[3]), 16'h00AB);

      loadReg(16'h0040, 2'b10);
      pcsrc = 2'b10; pcen = 1;
      applyStimulus();
      checkOutput("jr_pc", int'(bus.adr), 16'h0040);
      pcsrc = 2'b11;
      applyStimulus();
      checkOutput("hold_pc", int'(bus.adr), 16'h0040);

      idleCtl();
      bus.mem_ready = 0; reset = 1;
      applyStimulus();
      reset = 0; bus.mem_ready = 1;
      checkOutput("rststall_pc", int'(bus.adr), 0);
      checkOutput("rststall_carry", int'(carry_flag), 0);
      checkOutput("rststall_zflag", int'(zero_flag), 0);
      checkOutput("rststall_r1", int'(dut.rf_q[1]), 0);

      // op=7, ra=7, rb=0, rc=7, imm6 negative, imm9 positive, cz=10
      fetchCtl(16'h7E3E);
      applyStimulus();
      loadReg(16'hFFFF, 2'b10);
      pcsrc = 2'b10; pcen = 1;
      applyStimulus();
      checkOutput("pc_max", int'(bus.adr), 16'hFFFF);
      idleCtl();
      pcen = 1; alusrcb = 2'b01;
      applyStimulus();
      checkOutput("pc_wrap", int'(bus.adr), 16'h0000);

      for (int sel = 0; sel < 8; sel++) begin
         for (int b = 0; b < 4; b++) begin
            idleCtl();
            alusrca = 1; alusrcb = b[1:0]; alucontrol = sel[2:0];
            flagwrite = 1; condwb = 1; regwrite = 1; regdst = b[1:0];
            bus.readdata = 16'(16'h1357 * (sel + b + 1));
            applyStimulus();
         end
      end

      idleCtl();
      applyStimulus(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
